// File: rtl/i2s_clkgen.sv
// Master-mode I2S bclk/lrclk generator driven by a fractional phase accumulator.
// Define I2S_CLKGEN_SLOT_CFG_EN to add a runtime slot_w port in place of the SLOT_W parameter.
module i2s_clkgen #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SLOT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
`ifdef I2S_CLKGEN_SLOT_CFG_EN
  input  logic [6:0]       slot_w,
`endif
  input  logic [ACC_W-1:0] inc,
  output logic             bclk,
  output logic             lrclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             frame_start,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       slot_cur;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic             carry, fall_ev, wrap, term;

`ifdef I2S_CLKGEN_SLOT_CFG_EN
  logic [6:0] slot_q, slot_d, slot_clamped;

  always_comb begin
    if (slot_w < 7'd2) begin
      slot_clamped = 7'd2;
    end else if (slot_w > 7'd64) begin
      slot_clamped = 7'd64;
    end else begin
      slot_clamped = slot_w;
    end
  end

  // Width only changes where a frame begins, so a frame is never split.
  assign slot_d = fs_d ? slot_clamped : slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= 7'd2;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_cur = slot_q;
`else
  assign slot_cur = 7'(SLOT_W);
`endif

  assign sum     = {1'b0, acc_q} + {1'b0, inc};
  assign carry   = sum[ACC_W];
  assign fall_ev = (state_q != StIdle) && carry && bclk_q;
  assign wrap    = fall_ev && (bit_cnt_q == slot_cur - 7'd1);
  // The fall that would start a new frame ends a drain instead.
  assign term    = wrap && lrclk_q && (state_q == StDrain) && !enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (term) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    fs_d      = 1'b0;
    busy      = (state_q != StIdle);
    if (state_q == StIdle) begin
      acc_d     = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      fs_d      = enable;
    end else if (term) begin
      acc_d     = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
    end else begin
      acc_d = sum[ACC_W-1:0];
      if (carry) begin
        bclk_d = ~bclk_q;
        rise_d = ~bclk_q;
        fall_d = bclk_q;
      end
      if (fall_ev) begin
        if (wrap) begin
          bit_cnt_d = '0;
          lrclk_d   = ~lrclk_q;
          fs_d      = lrclk_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fs_q      <= fs_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_i2s_clkgen.sv
// Self-checking bench for i2s_clkgen (ACC_W=8, SLOT_W=4); strobe timing is scoreboarded.
// Exercises slot_w reconfiguration when I2S_CLKGEN_SLOT_CFG_EN is defined.
module tb_i2s_clkgen;

  localparam int unsigned ACC_W  = 8;
  localparam int unsigned SLOT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [ACC_W-1:0] inc = 8'd64;
  logic             bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy;
`ifdef I2S_CLKGEN_SLOT_CFG_EN
  logic [6:0]       slot_w = 7'd4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int base     = 0;
  bit mon_en   = 1'b0;
  // Expected strobe cycles: 0 = bclk_rise, 1 = bclk_fall, 2 = frame_start.
  int exp_q[3][$];

  i2s_clkgen #(
    .ACC_W (ACC_W),
    .SLOT_W(SLOT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef I2S_CLKGEN_SLOT_CFG_EN
    .slot_w     (slot_w),
`endif
    .inc        (inc),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int i);
    case (i)
      0:       return "bclk_rise";
      1:       return "bclk_fall";
      default: return "frame_start";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [2:0] obs;
    obs = {frame_start, bclk_fall, bclk_rise};
    if (bclk_rise) rise_cnt++;
    if (mon_en) begin
      n_checks++;
      if ((bclk_rise && bclk_fall) || (!busy && (bclk_rise || bclk_fall))) begin
        n_fail++;
        $display("FAIL strobe_excl: cycle %0d rise=%0b fall=%0b busy=%0b, required exclusive and none idle",
                 cyc, bclk_rise, bclk_fall, busy);
      end
      for (int i = 0; i < 3; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_missed: not observed, expected at cycle %0d", kind_name(i),
                   exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        if (obs[i]) begin
          n_checks++;
          if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
            void'(exp_q[i].pop_front());
          end else begin
            n_fail++;
            $display("FAIL %s_timing: seen at cycle %0d, required none there", kind_name(i), cyc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    inc = 8'd64;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bclk !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b bclk=%b, required 0 0", busy, bclk);
    end
    mon_en = 1'b1;
  endtask

  // inc=64: bclk toggles every 4 clk; rises at 4+8j, falls at 8+8j, frames every 64.
  task automatic test_run();
    @(negedge clk);
    rise_cnt = 0;
    enable = 1'b1;
    base = cyc + 1;
    for (int j = 0; j < 24; j++) exp_q[0].push_back(base + 4 + 8 * j);
    for (int j = 0; j < 23; j++) exp_q[1].push_back(base + 8 + 8 * j);
    for (int j = 0; j < 3; j++) exp_q[2].push_back(base + 64 * j);
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || lrclk !== 1'(((k / 32) % 2))
          || bclk !== 1'(k >= 4 && ((k - 4) % 8) < 4)) begin
        n_fail++;
        $display("FAIL run_levels: k=%0d busy=%b lrclk=%b bclk=%b, required 1 %0d %0d", k, busy,
                 lrclk, bclk, (k / 32) % 2, (k >= 4 && ((k - 4) % 8) < 4));
      end
    end
  endtask

  // Continues the run of test_run; enable drops mid left slot of the fourth frame.
  task automatic test_drain();
    exp_q[2].push_back(base + 192);
    for (int j = 0; j < 8; j++) exp_q[1].push_back(base + 192 + 8 * j);
    for (int j = 0; j < 8; j++) exp_q[0].push_back(base + 196 + 8 * j);
    for (int k = 192; k < 264; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 256) begin
        if (busy !== 1'b1 || lrclk !== 1'(((k / 32) % 2)) || bclk !== 1'(((k - 4) % 8) < 4)) begin
          n_fail++;
          $display("FAIL drain_levels: k=%0d busy=%b lrclk=%b bclk=%b, required 1 %0d %0d", k, busy,
                   lrclk, bclk, (k / 32) % 2, ((k - 4) % 8) < 4);
        end
      end else if ({busy, lrclk, bclk} !== 3'b000) begin
        n_fail++;
        $display("FAIL drain_end: k=%0d busy/lrclk/bclk=%b, required 000", k, {busy, lrclk, bclk});
      end
      if (k == 200) enable = 1'b0;
    end
    n_checks++;
    if (rise_cnt != 32) begin
      n_fail++;
      $display("FAIL drain_rise_total: got %0d rises, required 32", rise_cnt);
    end
  endtask

  task automatic test_drain_reenable();
    @(negedge clk);
    enable = 1'b1;
    base = cyc + 1;
    for (int j = 0; j < 24; j++) exp_q[0].push_back(base + 4 + 8 * j);
    for (int j = 0; j < 23; j++) exp_q[1].push_back(base + 8 + 8 * j);
    for (int j = 0; j < 3; j++) exp_q[2].push_back(base + 64 * j);
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || lrclk !== 1'(((k / 32) % 2))
          || bclk !== 1'(k >= 4 && ((k - 4) % 8) < 4)) begin
        n_fail++;
        $display("FAIL reenable_levels: k=%0d busy=%b lrclk=%b bclk=%b, required 1 %0d %0d", k,
                 busy, lrclk, bclk, (k / 32) % 2, (k >= 4 && ((k - 4) % 8) < 4));
      end
      if (k == 40) enable = 1'b0;
      if (k == 63) enable = 1'b1;
    end
  endtask

  // Still running in the right slot from test_drain_reenable.
  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b, required 000000",
               {bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    base = cyc + 1;
    exp_q[2].push_back(base);
    exp_q[0].push_back(base + 4);
    exp_q[0].push_back(base + 12);
    exp_q[1].push_back(base + 8);
    exp_q[1].push_back(base + 16);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || frame_start !== 1'(k == 0)) begin
        n_fail++;
        $display("FAIL restart: k=%0d busy=%b frame_start=%b, required 1 %0d", k, busy,
                 frame_start, k == 0);
      end
    end
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // inc=96: carries where floor(96*n/256) steps; toggles 2-3 clk apart.
  task automatic test_fractional();
    int last_tr;
    int rises_in_frame;
    logic prev_bclk;
    inc = 8'd96;
    enable = 1'b1;
    base = cyc + 1;
    exp_q[2].push_back(base);
    for (int n = 1; n < 300; n++) begin
      int t_prev;
      int t;
      t_prev = (96 * (n - 1)) / 256;
      t = (96 * n) / 256;
      if (t > t_prev) begin
        if (t % 2 == 1) exp_q[0].push_back(base + n);
        else exp_q[1].push_back(base + n);
        if (t % 16 == 0) exp_q[2].push_back(base + n);
      end
    end
    last_tr = -1;
    rises_in_frame = 0;
    prev_bclk = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bclk !== prev_bclk) begin
        if (last_tr >= 0) begin
          n_checks++;
          if (k - last_tr < 2 || k - last_tr > 3) begin
            n_fail++;
            $display("FAIL frac_width: k=%0d width %0d clk, required 2 or 3", k, k - last_tr);
          end
        end
        last_tr = k;
      end
      prev_bclk = bclk;
      if (frame_start && k > 0) begin
        n_checks++;
        if (rises_in_frame != 8) begin
          n_fail++;
          $display("FAIL frac_rises_per_frame: got %0d, required 8", rises_in_frame);
        end
        rises_in_frame = 0;
      end
      if (bclk_rise) rises_in_frame++;
    end
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    inc = 8'd64;
    @(negedge clk);
  endtask

`ifdef I2S_CLKGEN_SLOT_CFG_EN
  task automatic test_slot_cfg();
    int exp_lr;
    mon_en = 1'b0;
    slot_w = 7'd4;
    enable = 1'b1;
    for (int k = 0; k < 241; k++) begin
      @(negedge clk);
      if (k < 32) exp_lr = 0;
      else if (k < 64) exp_lr = 1;
      else if (k < 128) exp_lr = 0;
      else if (k < 192) exp_lr = 1;
      else if (k < 208) exp_lr = 0;
      else if (k < 224) exp_lr = 1;
      else exp_lr = 0;
      n_checks++;
      if (lrclk !== 1'(exp_lr)
          || frame_start !== 1'(k == 0 || k == 64 || k == 192 || k == 224)) begin
        n_fail++;
        $display("FAIL slot_cfg: k=%0d lrclk=%b frame_start=%b, required %0d %0d", k, lrclk,
                 frame_start, exp_lr, (k == 0 || k == 64 || k == 192 || k == 224));
      end
      if (k == 40) slot_w = 7'd8;
      if (k == 150) slot_w = 7'd1;
    end
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_drain();
    test_drain_reenable();
    test_reset_mid();
    test_fractional();
`ifdef I2S_CLKGEN_SLOT_CFG_EN
    test_slot_cfg();
`endif
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (exp_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL %s_leftover: %0d expected strobes never seen, required 0", kind_name(i),
                 exp_q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
